sram_responder: RTL and testbench

Synchronous target for the 8-bit asynchronous cellular-RAM pin interface (19-bit address, CE#, OE#, WE#, bidirectional DQ) driven by the system's external memory controller. Samples the controller's pins in the `sys_clock` domain, serves reads and writes from an internal block RAM, and drives DQ via the `cellular_ram_dq_o` / `cellular_ram_dq_t` pair into the existing IOBUF split. Used on-chip and in simulation as a loopback memory, so the controller and software can be exercised without the external device.

---
 rtl/sram_responder.sv | 151 +++++++++++++++
 tb/tb_sram_responder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_responder.sv
// Loopback target for the 8-bit asynchronous cellular-RAM pin interface.
// Controller pins are synchronised into sys_clock, decoded, and served from
// an internal byte-wide block RAM that aliases across the pin address space.
module sram_responder #(
    parameter int unsigned ADDR_WIDTH     = 19,
    parameter int unsigned MEM_ADDR_WIDTH = 12
) (
    input  logic                  sys_clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] cellular_ram_addr,
    input  logic                  cellular_ram_ce_n,
    input  logic                  cellular_ram_oen,
    input  logic                  cellular_ram_wen,
    input  logic [7:0]            cellular_ram_dq_i,
    output logic [7:0]            cellular_ram_dq_o,
    output logic [7:0]            cellular_ram_dq_t,
    output logic [15:0]           wr_count,
    output logic [15:0]           rd_count
);

    localparam int unsigned MemDepth = 1 << MEM_ADDR_WIDTH;

    typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

    // Control synchroniser stages, packed as {ce_n, oe_n, we_n}
    logic [2:0]                ctrl_s1_q, ctrl_s2_q;
    logic [MEM_ADDR_WIDTH-1:0] addr_s1_q, addr_s2_q;
    logic [7:0]                data_s1_q, data_s2_q;

    state_e                    state_q, state_d;
    logic [MEM_ADDR_WIDTH-1:0] hold_addr_q, hold_addr_d;
    logic [7:0]                hold_data_q, hold_data_d;
    logic [7:0]                dq_o_q, dq_o_d;
    logic                      dq_t_q, dq_t_d;
    logic [15:0]               wr_count_q, wr_count_d;
    logic [15:0]               rd_count_q, rd_count_d;

    logic [7:0]                mem_q [MemDepth];
    logic [7:0]                ram_rd_q;
    logic                      mem_we;
    logic                      rd_req;
    logic                      wr_act;

    // Upper address bits are ignored so the RAM aliases across the pin range
    if (MEM_ADDR_WIDTH < ADDR_WIDTH) begin : g_unused_addr
        logic unused_addr_hi;
        assign unused_addr_hi = ^cellular_ram_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH];
    end

    // Two-stage sampling of controls, address and data on a common schedule
    always_ff @(posedge sys_clock or negedge reset) begin
        if (!reset) begin
            ctrl_s1_q <= 3'b111;
            ctrl_s2_q <= 3'b111;
            addr_s1_q <= '0;
            addr_s2_q <= '0;
            data_s1_q <= '0;
            data_s2_q <= '0;
        end else begin
            ctrl_s1_q <= {cellular_ram_ce_n, cellular_ram_oen, cellular_ram_wen};
            ctrl_s2_q <= ctrl_s1_q;
            addr_s1_q <= cellular_ram_addr[MEM_ADDR_WIDTH-1:0];
            addr_s2_q <= addr_s1_q;
            data_s1_q <= cellular_ram_dq_i;
            data_s2_q <= data_s1_q;
        end
    end

    assign rd_req = !ctrl_s2_q[2] && !ctrl_s2_q[1] && ctrl_s2_q[0];
    assign wr_act = !ctrl_s2_q[2] && !ctrl_s2_q[0];

    // Block RAM: registered read every cycle, write on write-access completion
    always_ff @(posedge sys_clock) begin
        if (mem_we) begin
            mem_q[hold_addr_q] <= hold_data_q;
        end
        ram_rd_q <= mem_q[addr_s2_q];
    end

    // Next-state, write commit, output and counter logic
    always_comb begin
        state_d     = state_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        dq_o_d      = dq_o_q;
        dq_t_d      = 1'b1;
        wr_count_d  = wr_count_q;
        rd_count_d  = rd_count_q;
        mem_we      = 1'b0;

        // Track the newest address/data while the write is still open
        if (wr_act) begin
            hold_addr_d = addr_s2_q;
            hold_data_d = data_s2_q;
        end

        unique case (state_q)
            StIdle: begin
                if (wr_act) begin
                    state_d = StWrite;
                end else if (rd_req) begin
                    state_d    = StRead;
                    rd_count_d = rd_count_q + 16'd1;
                end
            end
            StRead: begin
                dq_o_d = ram_rd_q;
                if (rd_req) begin
                    dq_t_d = 1'b0;
                end else begin
                    state_d = StIdle;
                end
            end
            StWrite: begin
                if (!wr_act) begin
                    mem_we     = 1'b1;
                    wr_count_d = wr_count_q + 16'd1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, hold, output and counter registers
    always_ff @(posedge sys_clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            hold_addr_q <= '0;
            hold_data_q <= '0;
            dq_o_q      <= '0;
            dq_t_q      <= 1'b1;
            wr_count_q  <= '0;
            rd_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            dq_o_q      <= dq_o_d;
            dq_t_q      <= dq_t_d;
            wr_count_q  <= wr_count_d;
            rd_count_q  <= rd_count_d;
        end
    end

    assign cellular_ram_dq_o = dq_o_q;
    assign cellular_ram_dq_t = {8{dq_t_q}};
    assign wr_count          = wr_count_q;
    assign rd_count          = rd_count_q;

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: directed pin-level accesses, a pin-history model
// of the bus timing rules checked every cycle, plus literal expectations.
module tb_sram_responder;

    localparam int unsigned AW = 19;
    localparam int unsigned MW = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] addr;
    logic          ce_n, oen, wen;
    logic [7:0]    dq_in;
    logic [7:0]    dq_o, dq_t;
    logic [15:0]   wr_count, rd_count;

    int n_checks = 0;
    int n_fail   = 0;

    sram_responder #(
        .ADDR_WIDTH     (AW),
        .MEM_ADDR_WIDTH (MW)
    ) dut (
        .sys_clock         (clk),
        .reset             (rst_n),
        .cellular_ram_addr (addr),
        .cellular_ram_ce_n (ce_n),
        .cellular_ram_oen  (oen),
        .cellular_ram_wen  (wen),
        .cellular_ram_dq_i (dq_in),
        .cellular_ram_dq_o (dq_o),
        .cellular_ram_dq_t (dq_t),
        .wr_count          (wr_count),
        .rd_count          (rd_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pin samples of the last four edges (index j = sample taken j edges ago).
    // Bus rules: drive after 4 edges of read, release 3 edges after the read ends,
    // data follows the address seen 3 edges back, a write commits the address/data
    // seen just before the last low sample, 3 edges after that sample.
    logic [7:0]  m_mem   [4096];
    bit          m_valid [4096];
    bit          h_rd    [4];
    bit          h_wr    [4];
    logic [11:0] h_addr  [4];
    logic [7:0]  h_dq    [4];
    logic [15:0] m_wr_evt = '0;
    logic [15:0] m_rd_cnt = '0;
    logic [15:0] m_wr_base = '0;

    initial forever begin
        @(posedge clk);
        for (int i = 3; i > 0; i--) begin
            h_rd[i]   = h_rd[i-1];
            h_wr[i]   = h_wr[i-1];
            h_addr[i] = h_addr[i-1];
            h_dq[i]   = h_dq[i-1];
        end
        if (!rst_n) begin
            h_rd[0]   = 1'b0;
            h_wr[0]   = 1'b0;
            h_addr[0] = '0;
            h_dq[0]   = '0;
            m_wr_evt  = '0;
            m_rd_cnt  = '0;
        end else begin
            h_rd[0]   = !ce_n && !oen && wen;
            h_wr[0]   = !ce_n && !wen;
            h_addr[0] = addr[11:0];
            h_dq[0]   = dq_in;
            if (h_wr[3] && !h_wr[2]) begin
                m_mem[h_addr[3]]   = h_dq[3];
                m_valid[h_addr[3]] = 1'b1;
                m_wr_evt           = m_wr_evt + 16'd1;
            end
            if (h_rd[2] && !h_rd[3]) m_rd_cnt = m_rd_cnt + 16'd1;
        end
    end

    // Compare DUT outputs against the model on every falling edge
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            check("rst_dq_t", 32'(dq_t), 32'hFF);
            check("rst_dq_o", 32'(dq_o), 32'h0);
            check("rst_wr_count", 32'(wr_count), 32'h0);
            check("rst_rd_count", 32'(rd_count), 32'h0);
        end else begin
            check("mdl_dq_t", 32'(dq_t), (h_rd[2] && h_rd[3]) ? 32'h00 : 32'hFF);
            if (h_rd[2] && h_rd[3] && m_valid[h_addr[3]])
                check("mdl_dq_o", 32'(dq_o), 32'(m_mem[h_addr[3]]));
            check("mdl_wr_count", 32'(wr_count), 32'(16'(m_wr_base + m_wr_evt)));
            check("mdl_rd_count", 32'(rd_count), 32'(m_rd_cnt));
        end
    end

    // All stimulus tasks start and end one time unit after a rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        ce_n = 1'b1;
        oen  = 1'b1;
        wen  = 1'b1;
        repeat (n) cyc();
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [7:0] d);
        addr  = a;
        dq_in = d;
        oen   = 1'b1;
        ce_n  = 1'b0;
        wen   = 1'b0;
        repeat (6) cyc();
        wen  = 1'b1;
        ce_n = 1'b1;
        repeat (5) cyc();
    endtask

    task automatic read_check(input logic [AW-1:0] a, input logic [7:0] exp, input string nm);
        addr = a;
        wen  = 1'b1;
        ce_n = 1'b0;
        oen  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check({nm, "_hiz3"}, 32'(dq_t), 32'hFF);
        @(negedge clk);
        check({nm, "_drv4"}, 32'(dq_t), 32'h00);
        check({nm, "_data"}, 32'(dq_o), 32'(exp));
        cyc();
        cyc();
        ce_n = 1'b1;
        oen  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check({nm, "_hold2"}, 32'(dq_t), 32'h00);
        @(negedge clk);
        check({nm, "_rel3"}, 32'(dq_t), 32'hFF);
        cyc();
        idle(4);
    endtask

    initial begin
        addr  = '0;
        ce_n  = 1'b1;
        oen   = 1'b1;
        wen   = 1'b1;
        dq_in = '0;
        rst_n = 1'b0;
        repeat (3) cyc();
        check("reset_dq_t", 32'(dq_t), 32'hFF);
        check("reset_dq_o", 32'(dq_o), 32'h0);
        rst_n = 1'b1;
        idle(4);

        // Basic write then read
        write(19'h00010, 8'hA5);
        read_check(19'h00010, 8'hA5, "rd_a5");
        check("cnt1_wr", 32'(wr_count), 32'd1);
        check("cnt1_rd", 32'(rd_count), 32'd1);

        // Aliasing of the upper address bits
        write(19'h01234, 8'h3C);
        read_check(19'h00234, 8'h3C, "rd_alias");

        // OE# and WE# low together: write wins, bus never driven
        addr  = 19'h00050;
        dq_in = 8'h77;
        ce_n  = 1'b0;
        oen   = 1'b0;
        wen   = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("both_low_hiz", 32'(dq_t), 32'hFF);
            cyc();
        end
        idle(5);
        check("both_low_wr", 32'(wr_count), 32'd3);
        check("both_low_rd", 32'(rd_count), 32'd2);
        read_check(19'h00050, 8'h77, "rd_77");

        // Address stepping inside one read
        write(19'h00000, 8'h11);
        write(19'h00001, 8'h22);
        write(19'h00002, 8'h33);
        addr = 19'h00000;
        ce_n = 1'b0;
        oen  = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("step0_data", 32'(dq_o), 32'h11);
        cyc();
        cyc();
        for (int j = 1; j < 3; j++) begin
            addr = AW'(j);
            repeat (3) @(posedge clk);
            @(negedge clk);
            check("step_old", 32'(dq_o), (j == 1) ? 32'h11 : 32'h22);
            @(negedge clk);
            check("step_new", 32'(dq_o), (j == 1) ? 32'h22 : 32'h33);
            cyc();
            cyc();
        end
        idle(6);
        check("step_rd_count", 32'(rd_count), 32'd4);
        check("step_wr_count", 32'(wr_count), 32'd6);

        // Reset during a write: write dropped, counters cleared
        write(19'h00005, 8'h42);
        addr  = 19'h00005;
        dq_in = 8'h99;
        ce_n  = 1'b0;
        wen   = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b0;
        #1;
        check("rstwr_dq_t", 32'(dq_t), 32'hFF);
        check("rstwr_wr_count", 32'(wr_count), 32'd0);
        check("rstwr_rd_count", 32'(rd_count), 32'd0);
        ce_n = 1'b1;
        wen  = 1'b1;
        repeat (4) cyc();
        rst_n = 1'b1;
        idle(3);
        read_check(19'h00005, 8'h42, "rd_after_rst");
        check("rstwr_wr_after", 32'(wr_count), 32'd0);
        check("rstwr_rd_after", 32'(rd_count), 32'd1);

        // Reset while the bus is driven releases it at once
        addr = 19'h00010;
        ce_n = 1'b0;
        oen  = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rstrd_pre_drv", 32'(dq_t), 32'h00);
        #1;
        rst_n = 1'b0;
        #1;
        check("rstrd_dq_t", 32'(dq_t), 32'hFF);
        check("rstrd_dq_o", 32'(dq_o), 32'h0);
        ce_n = 1'b1;
        oen  = 1'b1;
        repeat (4) cyc();
        rst_n = 1'b1;
        idle(3);
        read_check(19'h00010, 8'hA5, "rd_after_rst2");

        // Counter wrap: preset near the top, then back-to-back short write pulses
        force dut.wr_count_q = 16'hFFFD;
        m_wr_base = 16'hFFFD - m_wr_evt;
        cyc();
        release dut.wr_count_q;
        addr  = 19'h00077;
        dq_in = 8'h5A;
        ce_n  = 1'b0;
        repeat (5) begin
            wen = 1'b0;
            cyc();
            wen = 1'b1;
            cyc();
        end
        idle(6);
        check("wrap_wr_count", 32'(wr_count), 32'h0002);
        read_check(19'h00077, 8'h5A, "rd_wrap");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
